// File: rtl/uart_pkg.sv
// Shared UART constants and the byte type used by the receive-side buffer.
package uart_pkg;

   localparam int unsigned UART_DATA_W            = 8;
   localparam int unsigned UART_RX_FIFO_DEPTH_DEF = 16;
   localparam int unsigned UART_RX_TIMEOUT_DEF    = 17_360;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Dual-port storage array: synchronous write, asynchronous (show-ahead) read.
module uart_fifo_mem #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [DATA_W-1:0]        i_wr_data,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [DATA_W-1:0]        o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Contents are intentionally not reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: overrun detection and an optional
// character timeout compiled in with UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH          = UART_RX_FIFO_DEPTH_DEF,
   parameter int unsigned TIMEOUT_CYCLES = UART_RX_TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [UART_DATA_W-1:0] rx_data,
   input  logic                   rx_valid,
   output logic [UART_DATA_W-1:0] m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty,
   output logic                   overrun,
   input  logic                   overrun_clr,
   output logic                   timeout
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [LW-1:0]      r_wr_ptr;
   logic [LW-1:0]      r_rd_ptr;
   logic               r_overrun;
   logic [LW-1:0]      w_level;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_drop;
   uart_byte_t         w_rd_data;

   // Occupancy from the extra-MSB pointers, modulo 2*DEPTH.
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_full  = (w_level == LW'(DEPTH));
   assign w_empty = (w_level == '0);

   // A pop frees a slot in the same cycle, so a full buffer still accepts a byte.
   assign w_pop  = ~w_empty & m_ready;
   assign w_push = rx_valid & (~w_full | w_pop);
   assign w_drop = rx_valid & w_full & ~w_pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + LW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LW'(1);
         end
      end
   end

   // Sticky overrun; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (overrun_clr) begin
         r_overrun <= 1'b0;
      end
   end

   uart_fifo_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (UART_DATA_W)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_data (rx_data),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .o_rd_data (w_rd_data)
   );

`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_to_cnt;

   // Idle counter: restarts on any traffic or while empty, saturates at TO_MAX.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_to_cnt <= '0;
      end else if (w_push | w_pop | w_empty) begin
         r_to_cnt <= '0;
      end else if (r_to_cnt != TO_MAX) begin
         r_to_cnt <= r_to_cnt + CW'(1);
      end
   end

   assign timeout = (r_to_cnt == TO_MAX) & ~w_empty;
`else
   logic w_unused_timeout_cfg;

   assign w_unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
   assign timeout              = 1'b0;
`endif

   assign level   = w_level;
   assign full    = w_full;
   assign empty   = w_empty;
   assign m_valid = ~w_empty;
   assign m_data  = w_empty ? '0 : w_rd_data;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed stimulus queues expected bytes, a
// negedge monitor checks every popped byte; flags are checked after each edge.
module tb_uart_rx_fifo;

   localparam int DEPTH = 8;
   localparam int TO    = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [3:0] level;
   logic       full;
   logic       empty;
   logic       overrun;
   logic       overrun_clr;
   logic       timeout;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         m_lvl = 0;
   logic       m_ovr = 1'b0;
   int         m_cnt = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .level       (level),
      .full        (full),
      .empty       (empty),
      .overrun     (overrun),
      .overrun_clr (overrun_clr),
      .timeout     (timeout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: the byte presented while m_valid & m_ready is popped at the next edge.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: got %0h expected no byte", m_data);
            end else begin
               chk("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
         end else if (!m_valid) begin
            chk("idle_data_zero", 32'(m_data), 32'h0);
         end
      end
   end

   function automatic logic exp_timeout();
`ifdef UART_RX_FIFO_TIMEOUT_EN
      return (m_cnt == TO - 1) && (m_lvl > 0);
`else
      return 1'b0;
`endif
   endfunction

   // One clock of stimulus; the reference model is a plain occupancy count.
   task automatic cycle(input logic rv, input logic [7:0] d, input logic rdy, input logic clr);
      bit pop, push, drop, emp;
      rx_valid    = rv;
      rx_data     = d;
      m_ready     = rdy;
      overrun_clr = clr;
      emp  = (m_lvl == 0);
      pop  = rdy && !emp;
      push = rv && ((m_lvl < DEPTH) || pop);
      drop = rv && !push;
      if (push) exp_q.push_back(d);
      m_lvl = m_lvl + int'(push) - int'(pop);
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (push || pop || emp) m_cnt = 0;
      else if (m_cnt < TO - 1) m_cnt++;
      @(posedge clk);
      #1;
      rx_valid    = 1'b0;
      m_ready     = 1'b0;
      overrun_clr = 1'b0;
      chk("level",   32'(level),   32'(m_lvl));
      chk("full",    32'(full),    32'(m_lvl == DEPTH));
      chk("empty",   32'(empty),   32'(m_lvl == 0));
      chk("m_valid", 32'(m_valid), 32'(m_lvl != 0));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("timeout", 32'(timeout), 32'(exp_timeout()));
   endtask

   task automatic do_reset();
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      m_ready     = 1'b0;
      overrun_clr = 1'b0;
      reset_n     = 1'b0;
      m_lvl = 0;
      m_ovr = 1'b0;
      m_cnt = 0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level",   32'(level),   32'h0);
      chk("rst_empty",   32'(empty),   32'h1);
      chk("rst_full",    32'(full),    32'h0);
      chk("rst_m_valid", 32'(m_valid), 32'h0);
      chk("rst_m_data",  32'(m_data),  32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      reset_n = 1'b1;
   endtask

   task automatic fill();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      do_reset();

      // Basic ordering with show-ahead head byte
      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b0);
      chk("level_three", 32'(level), 32'h3);
      chk("head_0x11",   32'(m_data), 32'h11);
      drain(3);
      chk("empty_after_drain", 32'(empty), 32'h1);
      chk("m_data_zero_empty", 32'(m_data), 32'h00);

      // Fill to full, then one dropped byte
      fill();
      chk("full_set",   32'(full),  32'h1);
      chk("full_level", 32'(level), 32'(DEPTH));
      cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("overrun_on_drop", 32'(overrun), 32'h1);
      chk("level_after_drop", 32'(level), 32'(DEPTH));
      drain(DEPTH);

      // Full with simultaneous push and pop
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("overrun_cleared", 32'(overrun), 32'h0);
      fill();
      cycle(1'b1, 8'h5A, 1'b1, 1'b0);
      chk("full_pushpop_level",   32'(level),   32'(DEPTH));
      chk("full_pushpop_overrun", 32'(overrun), 32'h0);
      drain(DEPTH);

      // Drop and clear in the same cycle: set wins
      fill();
      cycle(1'b1, 8'hE1, 1'b0, 1'b0);
      cycle(1'b1, 8'hE2, 1'b0, 1'b1);
      chk("set_beats_clear", 32'(overrun), 32'h1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("lone_clear", 32'(overrun), 32'h0);
      drain(DEPTH);

      // Streaming through pointer wrap
      for (int i = 0; i < 3 * DEPTH; i++) begin
         cycle(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0);
         chk("stream_level_le1", 32'(level <= 4'd1), 32'h1);
      end
      drain(1);
      chk("stream_no_overrun", 32'(overrun), 32'h0);

      // Character timeout: one byte left unread
      cycle(1'b1, 8'hC3, 1'b0, 1'b0);
      repeat (6) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      chk("timeout_not_yet", 32'(timeout), 32'h0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
      chk("timeout_raised", 32'(timeout), 32'h1);
`else
      chk("timeout_tied_low", 32'(timeout), 32'h0);
`endif
      repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      drain(1);
      chk("timeout_after_pop", 32'(timeout), 32'h0);

      // Reset mid-stream discards buffered bytes
      cycle(1'b1, 8'h77, 1'b0, 1'b0);
      cycle(1'b1, 8'h88, 1'b0, 1'b0);
      do_reset();
      cycle(1'b1, 8'h99, 1'b0, 1'b0);
      chk("post_reset_head", 32'(m_data), 32'h99);
      drain(1);

      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
